// File: rtl/booth4_if.sv
// booth4_if: command/status bundle between the radix-4 Booth control unit
// and its datapath.
//   Commands  : Carga_QM, Carga_A, MoM2, Resta, Desplaza_AQ, Fin
//   Operands  : m_in (multiplicand), q_in (multiplier), N bits, signed
//   Status    : q1, q0, q_menos1 (recoding bits), producto (2N), valido
// master = control unit side, slave = datapath side.
interface booth4_if #(
    parameter int N = 4
);
    logic           Carga_QM;
    logic           Carga_A;
    logic           MoM2;
    logic           Resta;
    logic           Desplaza_AQ;
    logic           Fin;
    logic [N-1:0]   m_in;
    logic [N-1:0]   q_in;
    logic           q1;
    logic           q0;
    logic           q_menos1;
    logic [2*N-1:0] producto;
    logic           valido;

    modport master (
        output Carga_QM, Carga_A, MoM2, Resta, Desplaza_AQ, Fin, m_in, q_in,
        input  q1, q0, q_menos1, producto, valido
    );

    modport slave (
        input  Carga_QM, Carga_A, MoM2, Resta, Desplaza_AQ, Fin, m_in, q_in,
        output q1, q0, q_menos1, producto, valido
    );
endinterface

// File: rtl/booth4_datapath.sv
// booth4_datapath: register datapath of the radix-4 (modified Booth) signed
// multiplier. Holds multiplicand M, accumulator A (N+2 bits), multiplier Q
// and the extra bit q_menos1; executes load / add-sub / shift-by-2 commands
// and captures the 2N-bit product once per operation when Fin is seen.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset; clears all state
//   bus    - booth4_if slave: commands in, recoding bits and product out
// Command priority: Carga_QM > Carga_A > Desplaza_AQ. Fin is evaluated in
// parallel with whichever command executes.
module booth4_datapath #(
    parameter int N = 4
) (
    input  logic     clk,
    input  logic     reset,
    booth4_if.slave  bus
);

    logic [N+1:0]   a_reg;
    logic [N-1:0]   m_reg;
    logic [N-1:0]   q_reg;
    logic           qm1_reg;
    logic [2*N-1:0] prod_reg;
    logic           valid_reg;

    logic [N+1:0]   m_ext;
    logic [N+1:0]   op;
    logic [N+1:0]   a_sum;

    // N+2 bits of A hold any A +/- 2M without overflow, so plain modular
    // arithmetic is exact here.
    always_comb begin
        m_ext = {{2{m_reg[N-1]}}, m_reg};
        op    = bus.MoM2 ? {m_ext[N:0], 1'b0} : m_ext;
        a_sum = bus.Resta ? (a_reg - op) : (a_reg + op);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            qm1_reg   <= 1'b0;
            prod_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (bus.Carga_QM) begin
                m_reg   <= bus.m_in;
                q_reg   <= bus.q_in;
                a_reg   <= '0;
                qm1_reg <= 1'b0;
            end else if (bus.Carga_A) begin
                a_reg <= a_sum;
            end else if (bus.Desplaza_AQ) begin
                qm1_reg <= q_reg[1];
                q_reg   <= {a_reg[1:0], q_reg[N-1:2]};
                a_reg   <= {a_reg[N+1], a_reg[N+1], a_reg[N+1:2]};
            end

            // One capture per operation: once valido is set, further Fin
            // cycles leave the product untouched.
            if (bus.Fin && !valid_reg) begin
                prod_reg  <= {a_reg[N-1:0], q_reg};
                valid_reg <= 1'b1;
            end

            // A load starts a new operation, so it wins over a same-cycle
            // capture and the old result is no longer flagged valid.
            if (bus.Carga_QM) begin
                valid_reg <= 1'b0;
            end
        end
    end

    // Recoding bits come straight from registers so the control unit sees
    // values that are stable for the whole cycle.
    assign bus.q1       = q_reg[1];
    assign bus.q0       = q_reg[0];
    assign bus.q_menos1 = qm1_reg;
    assign bus.producto = prod_reg;
    assign bus.valido   = valid_reg;

endmodule

// File: tb/tb_booth4_datapath.sv
module tb_booth4_datapath;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    booth4_if #(.N(N)) bus();

    booth4_datapath #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic prev_valido = 1'b0;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[$] = '{
        '{4'b0011, 4'b0101, 8'h0F},   //  3 *  5 =  15
        '{4'b1000, 4'b1000, 8'h40},   // -8 * -8 =  64
        '{4'b1000, 4'b0111, 8'hC8},   // -8 *  7 = -56
        '{4'b0111, 4'b1111, 8'hF9},   //  7 * -1 =  -7
        '{4'b1101, 4'b0110, 8'hEE},   // -3 *  6 = -18
        '{4'b0000, 4'b1011, 8'h00},   //  0 * -5 =   0
        '{4'b0101, 4'b1010, 8'hE2}    //  5 * -6 = -30
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rising valido must match the oldest pending result.
    always @(negedge clk) begin
        if (bus.valido === 1'b1 && prev_valido === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valido: producto %0h with nothing expected", bus.producto);
            end else begin
                check("producto", 32'(bus.producto), 32'(exp_q.pop_front()));
            end
        end
        prev_valido = bus.valido;
    end

    task automatic clear_cmds();
        bus.Carga_QM    = 1'b0;
        bus.Carga_A     = 1'b0;
        bus.MoM2        = 1'b0;
        bus.Resta       = 1'b0;
        bus.Desplaza_AQ = 1'b0;
        bus.Fin         = 1'b0;
    endtask

    // Control-unit model of the radix-4 recoding table.
    task automatic set_add(input logic [2:0] b);
        bus.Carga_A = 1'b0;
        bus.MoM2    = 1'b0;
        bus.Resta   = 1'b0;
        case (b)
            3'b001, 3'b010: begin bus.Carga_A = 1'b1; end
            3'b011:         begin bus.Carga_A = 1'b1; bus.MoM2 = 1'b1; end
            3'b100:         begin bus.Carga_A = 1'b1; bus.MoM2 = 1'b1; bus.Resta = 1'b1; end
            3'b101, 3'b110: begin bus.Carga_A = 1'b1; bus.Resta = 1'b1; end
            default:        ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp, input int hold);
        @(negedge clk);
        clear_cmds();
        bus.Carga_QM = 1'b1;
        bus.m_in = m;
        bus.q_in = q;
        exp_q.push_back(exp);
        @(negedge clk);
        check("valido_clear", 32'(bus.valido), 32'd0);
        check("recode1", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'({q[1], q[0], 1'b0}));
        clear_cmds();
        set_add({q[1], q[0], 1'b0});
        bus.m_in = ~m;
        bus.q_in = ~q;
        @(negedge clk);
        clear_cmds();
        bus.Desplaza_AQ = 1'b1;
        @(negedge clk);
        check("recode2", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'({q[3], q[2], q[1]}));
        clear_cmds();
        set_add({q[3], q[2], q[1]});
        @(negedge clk);
        clear_cmds();
        bus.Desplaza_AQ = 1'b1;
        @(negedge clk);
        check("valido_early", 32'(bus.valido), 32'd0);
        clear_cmds();
        bus.Fin = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("valido_set", 32'(bus.valido), 32'd1);
            check("producto_hold", 32'(bus.producto), 32'(exp));
            bus.Desplaza_AQ = (i % 2 == 0);
            bus.m_in = 4'(i);
            bus.q_in = 4'(~i);
        end
        clear_cmds();
    endtask

    initial begin
        logic [7:0] p;
        int mi, qi;
        clear_cmds();
        bus.m_in = '0;
        bus.q_in = '0;
        reset = 1'b1;
        #12;
        check("rst_bits", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'd0);
        check("rst_producto", 32'(bus.producto), 32'd0);
        check("rst_valido", 32'(bus.valido), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors through the full controller sequence.
        foreach (vecs[k]) run_op(vecs[k].m, vecs[k].q, vecs[k].p, 1);

        // Fin held 10 cycles, operands and shifts churning underneath.
        run_op(4'b0011, 4'b0101, 8'h0F, 10);

        // Priority: all three commands at once; only the load may happen.
        @(negedge clk);
        clear_cmds();
        bus.Carga_QM = 1'b1;
        bus.Carga_A = 1'b1;
        bus.Desplaza_AQ = 1'b1;
        bus.MoM2 = 1'b1;
        bus.m_in = 4'b0101;
        bus.q_in = 4'b0110;
        @(negedge clk);
        check("prio_valido", 32'(bus.valido), 32'd0);
        check("prio_bits", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'b100);
        clear_cmds();
        bus.Fin = 1'b1;
        exp_q.push_back(8'h06);
        @(negedge clk);
        clear_cmds();

        // 2M subtract: M=3, A=0 -> A=-6 (111010); producto = {1010, 1000}.
        @(negedge clk);
        clear_cmds();
        bus.Carga_QM = 1'b1;
        bus.m_in = 4'b0011;
        bus.q_in = 4'b1000;
        @(negedge clk);
        clear_cmds();
        bus.Carga_A = 1'b1;
        bus.MoM2 = 1'b1;
        bus.Resta = 1'b1;
        @(negedge clk);
        clear_cmds();
        bus.Fin = 1'b1;
        exp_q.push_back(8'hA8);
        @(negedge clk);
        clear_cmds();

        // Reset in cycle 3 of an operation, mid-clock.
        @(negedge clk);
        clear_cmds();
        bus.Carga_QM = 1'b1;
        bus.m_in = 4'b0111;
        bus.q_in = 4'b1111;
        @(negedge clk);
        clear_cmds();
        set_add(3'b110);
        @(negedge clk);
        clear_cmds();
        bus.Desplaza_AQ = 1'b1;
        @(negedge clk);
        check("pre_reset_bits", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'b111);
        clear_cmds();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_bits", 32'({bus.q1, bus.q0, bus.q_menos1}), 32'd0);
        check("midrst_producto", 32'(bus.producto), 32'd0);
        check("midrst_valido", 32'(bus.valido), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(4'b0110, 4'b1001, 8'hD6, 1);   // 6 * -7 = -42

        // Exhaustive sweep against a signed reference product.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                mi = $signed(4'(i));
                qi = $signed(4'(j));
                p = 8'(mi * qi);
                run_op(4'(i), 4'(j), p, 1);
            end
        end

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
